// File: rtl/game_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : game_flow_ctrl
//  Description : Game-level sequencer for the Frogger datapath.
//                Walks title -> play -> death -> game over, owns the lives,
//                level and high-score state, gates the frogger core through
//                play_en and issues one-cycle game_reset / frog_respawn
//                pulses. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_flow_ctrl #(
  parameter int         LIVES        = 3,
  parameter int         DEATH_FRAMES = 60,
  parameter int         OVER_FRAMES  = 180,
  parameter logic [7:0] START_KEY    = 8'h28,
  parameter logic [7:0] CLEAR_KEY    = 8'h29
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  keycode,
  input  logic        frame_tick,
  input  logic        frog_hit,
  input  logic        frog_home,
  input  logic [15:0] score,
  output logic [1:0]  game_state,
  output logic        play_en,
  output logic        game_reset,
  output logic        frog_respawn,
  output logic [1:0]  lives,
  output logic [2:0]  level,
  output logic [15:0] high_score
);

  // Timer is sized for the longer of the two timed states; it never wraps
  // because each timed state leaves exactly when its end count is reached.
  localparam int MAX_FRAMES = (DEATH_FRAMES > OVER_FRAMES) ? DEATH_FRAMES : OVER_FRAMES;
  localparam int TW         = $clog2(MAX_FRAMES + 1);

  localparam logic [TW-1:0] DEATH_END  = TW'(DEATH_FRAMES);
  localparam logic [TW-1:0] OVER_END   = TW'(OVER_FRAMES);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [1:0]    LIVES_INIT = 2'(LIVES);
  localparam logic [2:0]    LEVEL_MAX  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_DYING = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  state_t         state_q,        state_d;
  logic [7:0]     key_q;
  logic [TW-1:0]  timer_q,        timer_d;
  logic [1:0]     lives_q,        lives_d;
  logic [2:0]     level_q,        level_d;
  logic [15:0]    high_score_q,   high_score_d;
  logic           play_en_q;
  logic           game_reset_q,   game_reset_d;
  logic           frog_respawn_q, frog_respawn_d;

  logic           start_ev;
  logic           clear_ev;
  logic           hs_clear;
  logic [TW-1:0]  timer_inc;

  // Key events fire only on the cycle a key first appears, so holding a key
  // down produces a single start or clear.
  assign start_ev  = (keycode == START_KEY) && (key_q != START_KEY);
  assign clear_ev  = (keycode == CLEAR_KEY) && (key_q != CLEAR_KEY);
  assign timer_inc = timer_q + TIMER_ONE;

  // Next-state and next-output decode; an abort key outranks everything.
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    lives_d        = lives_q;
    level_d        = level_q;
    game_reset_d   = 1'b0;
    frog_respawn_d = 1'b0;
    hs_clear       = 1'b0;

    if (clear_ev && (state_q != ST_IDLE)) begin
      // Abort the running game; the high score survives an abort.
      state_d      = ST_IDLE;
      game_reset_d = 1'b1;
      timer_d      = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_ev) begin
            state_d      = ST_PLAY;
            game_reset_d = 1'b1;
            lives_d      = LIVES_INIT;
            level_d      = 3'd0;
            timer_d      = '0;
          end else if (clear_ev) begin
            hs_clear = 1'b1;
          end
        end

        ST_PLAY: begin
          // A hit in the same cycle as reaching home costs the life and
          // forfeits the level-up.
          if (frog_hit) begin
            state_d = ST_DYING;
            timer_d = '0;
            if (lives_q != 2'd0) begin
              lives_d = lives_q - 2'd1;
            end
          end else if (frog_home) begin
            if (level_q != LEVEL_MAX) begin
              level_d = level_q + 3'd1;
            end
            frog_respawn_d = 1'b1;
          end
        end

        ST_DYING: begin
          if (frame_tick) begin
            timer_d = timer_inc;
            if (timer_inc == DEATH_END) begin
              timer_d = '0;
              if (lives_q == 2'd0) begin
                state_d = ST_OVER;
              end else begin
                state_d        = ST_PLAY;
                frog_respawn_d = 1'b1;
              end
            end
          end
        end

        ST_OVER: begin
          // Start only dismisses the game-over screen; a further start
          // edge from IDLE is needed to begin a new game.
          if (start_ev) begin
            state_d = ST_IDLE;
            timer_d = '0;
          end else if (frame_tick) begin
            timer_d = timer_inc;
            if (timer_inc == OVER_END) begin
              state_d = ST_IDLE;
              timer_d = '0;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      endcase
    end

    // High score tracks the live score in every state, except on the
    // cycle where it is being explicitly cleared.
    high_score_d = high_score_q;
    if (hs_clear) begin
      high_score_d = '0;
    end else if (score > high_score_q) begin
      high_score_d = score;
    end
  end

  // State and output registers; reset drops any pending pulses at once.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= ST_IDLE;
      key_q          <= 8'h00;
      timer_q        <= '0;
      lives_q        <= LIVES_INIT;
      level_q        <= 3'd0;
      high_score_q   <= 16'd0;
      play_en_q      <= 1'b0;
      game_reset_q   <= 1'b0;
      frog_respawn_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      key_q          <= keycode;
      timer_q        <= timer_d;
      lives_q        <= lives_d;
      level_q        <= level_d;
      high_score_q   <= high_score_d;
      play_en_q      <= (state_d == ST_PLAY);
      game_reset_q   <= game_reset_d;
      frog_respawn_q <= frog_respawn_d;
    end
  end

  assign game_state   = state_q;
  assign play_en      = play_en_q;
  assign game_reset   = game_reset_q;
  assign frog_respawn = frog_respawn_q;
  assign lives        = lives_q;
  assign level        = level_q;
  assign high_score   = high_score_q;

endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_flow_ctrl
//  Description : Self-checking bench for game_flow_ctrl: a vector table,
//                hand-written multi-cycle sequences and a randomized run
//                compared against a behavioural game model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_flow_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [7:0]  keycode;
  logic        frame_tick;
  logic        frog_hit;
  logic        frog_home;
  logic [15:0] score;
  logic [1:0]  game_state;
  logic        play_en;
  logic        game_reset;
  logic        frog_respawn;
  logic [1:0]  lives;
  logic [2:0]  level;
  logic [15:0] high_score;

  int checks = 0;
  int errors = 0;

  game_flow_ctrl dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .keycode      (keycode),
    .frame_tick   (frame_tick),
    .frog_hit     (frog_hit),
    .frog_home    (frog_home),
    .score        (score),
    .game_state   (game_state),
    .play_en      (play_en),
    .game_reset   (game_reset),
    .frog_respawn (frog_respawn),
    .lives        (lives),
    .level        (level),
    .high_score   (high_score)
  );

  always #5 Clk = ~Clk;

  // ---------------------------------------------------------------- model
  // Game rules tracked as plain integers: phase 0 title, 1 playing,
  // 2 dying, 3 game over.
  int         m_phase, m_lives, m_level, m_frames, m_best;
  logic [7:0] m_prev_key;
  int         m_gr, m_rs;

  task automatic model_reset();
    m_phase = 0; m_lives = 3; m_level = 0; m_frames = 0; m_best = 0;
    m_prev_key = 8'h00; m_gr = 0; m_rs = 0;
  endtask

  task automatic model_step(input logic [7:0] kc, input bit tk, input bit ht,
                            input bit hm, input int sc);
    bit enter_pressed, esc_pressed, wipe_best;
    enter_pressed = (kc == 8'h28) && (m_prev_key != 8'h28);
    esc_pressed   = (kc == 8'h29) && (m_prev_key != 8'h29);
    m_prev_key    = kc;
    m_gr = 0; m_rs = 0; wipe_best = 0;
    if (esc_pressed && m_phase != 0) begin
      m_phase = 0; m_gr = 1; m_frames = 0;
    end else if (m_phase == 0) begin
      if (enter_pressed) begin
        m_phase = 1; m_gr = 1; m_lives = 3; m_level = 0; m_frames = 0;
      end else if (esc_pressed) wipe_best = 1;
    end else if (m_phase == 1) begin
      if (ht) begin
        m_phase = 2; m_frames = 0;
        if (m_lives > 0) m_lives--;
      end else if (hm) begin
        m_level = (m_level >= 7) ? 7 : m_level + 1;
        m_rs = 1;
      end
    end else if (m_phase == 2) begin
      if (tk) m_frames++;
      if (m_frames == 60) begin
        m_frames = 0;
        if (m_lives == 0) m_phase = 3;
        else begin m_phase = 1; m_rs = 1; end
      end
    end else begin
      if (tk) m_frames++;
      if (enter_pressed || m_frames == 180) begin
        m_phase = 0; m_frames = 0;
      end
    end
    if (wipe_best) m_best = 0;
    else if (sc > m_best) m_best = sc;
  endtask

  // --------------------------------------------------------------- checks
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_state"},   int'(game_state),   m_phase);
    chk({tag, "_play_en"}, int'(play_en),      (m_phase == 1) ? 1 : 0);
    chk({tag, "_greset"},  int'(game_reset),   m_gr);
    chk({tag, "_respawn"}, int'(frog_respawn), m_rs);
    chk({tag, "_lives"},   int'(lives),        m_lives);
    chk({tag, "_level"},   int'(level),        m_level);
    chk({tag, "_hiscore"}, int'(high_score),   m_best);
  endtask

  // ------------------------------------------------------------- stimulus
  task automatic cyc(input logic [7:0] kc, input bit tk, input bit ht,
                     input bit hm, input int sc);
    keycode = kc; frame_tick = tk; frog_hit = ht; frog_home = hm; score = 16'(sc);
    @(posedge Clk);
    model_step(kc, tk, ht, hm, sc);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) cyc(8'h00, 1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic die();
    cyc(8'h00, 1'b0, 1'b1, 1'b0, 0);
    tick_n(60);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    keycode = 8'h00; frame_tick = 1'b0; frog_hit = 1'b0; frog_home = 1'b0; score = 16'd0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [7:0] kc;
    bit         tk, ht, hm;
    int         sc;
    int         e_state, e_lives, e_level, e_gr, e_rs, e_hs;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic [7:0] kc, input bit tk, input bit ht, input bit hm,
                         input int sc, input int st, input int lv, input int lvl,
                         input int gr, input int rs, input int hs);
    vec_t v;
    v.kc = kc; v.tk = tk; v.ht = ht; v.hm = hm; v.sc = sc;
    v.e_state = st; v.e_lives = lv; v.e_level = lvl; v.e_gr = gr; v.e_rs = rs; v.e_hs = hs;
    vq.push_back(v);
  endtask

  initial begin
    int rs_count;
    logic [7:0] rkc;
    int rsc;

    //        key    tk ht hm score  state lives lvl gr rs  hs
    add_vec(8'h00, 0, 0, 0,  0,    0,    3,   0, 0, 0,  0);
    add_vec(8'h28, 0, 0, 0,  0,    1,    3,   0, 1, 0,  0);
    add_vec(8'h28, 0, 0, 0,  0,    1,    3,   0, 0, 0,  0);
    add_vec(8'h00, 0, 0, 1,  0,    1,    3,   1, 0, 1,  0);
    add_vec(8'h00, 0, 0, 1, 50,    1,    3,   2, 0, 1, 50);
    add_vec(8'h00, 0, 1, 0,  0,    2,    2,   2, 0, 0, 50);
    add_vec(8'h00, 0, 0, 1,  0,    2,    2,   2, 0, 0, 50);
    add_vec(8'h29, 0, 0, 0,  0,    0,    2,   2, 1, 0, 50);
    add_vec(8'h00, 0, 0, 0,  0,    0,    2,   2, 0, 0, 50);
    add_vec(8'h29, 0, 0, 0, 70,    0,    2,   2, 0, 0,  0);
    add_vec(8'h29, 0, 0, 0, 70,    0,    2,   2, 0, 0, 70);
    add_vec(8'h00, 0, 1, 0,  0,    0,    2,   2, 0, 0, 70);

    // Reset values.
    do_reset();
    check_model("reset");
    chk("reset_state_const", int'(game_state), 0);
    chk("reset_lives_const", int'(lives), 3);

    // Vector table.
    for (int i = 0; i < vq.size(); i++) begin
      cyc(vq[i].kc, vq[i].tk, vq[i].ht, vq[i].hm, vq[i].sc);
      chk($sformatf("vec%0d_state", i),   int'(game_state),   vq[i].e_state);
      chk($sformatf("vec%0d_play_en", i), int'(play_en),      (vq[i].e_state == 1) ? 1 : 0);
      chk($sformatf("vec%0d_lives", i),   int'(lives),        vq[i].e_lives);
      chk($sformatf("vec%0d_level", i),   int'(level),        vq[i].e_level);
      chk($sformatf("vec%0d_greset", i),  int'(game_reset),   vq[i].e_gr);
      chk($sformatf("vec%0d_respawn", i), int'(frog_respawn), vq[i].e_rs);
      chk($sformatf("vec%0d_hiscore", i), int'(high_score),   vq[i].e_hs);
    end

    // Held Enter gives exactly one game_reset pulse.
    do_reset();
    rs_count = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(8'h28, 1'b0, 1'b0, 1'b0, 0);
      rs_count += int'(game_reset);
    end
    chk("held_enter_greset_count", rs_count, 1);
    chk("held_enter_state", int'(game_state), 1);
    chk("held_enter_lives", int'(lives), 3);
    chk("held_enter_level", int'(level), 0);

    // Death timing: 59 ticks still dying, respawn on the 60th.
    cyc(8'h00, 1'b0, 1'b1, 1'b0, 0);
    chk("hit_state", int'(game_state), 2);
    chk("hit_lives", int'(lives), 2);
    chk("hit_play_en", int'(play_en), 0);
    tick_n(59);
    chk("tick59_state", int'(game_state), 2);
    tick_n(1);
    chk("tick60_state", int'(game_state), 1);
    chk("tick60_respawn", int'(frog_respawn), 1);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 0);
    chk("after_respawn_pulse", int'(frog_respawn), 0);

    // Out of lives -> game over -> timed return to title.
    die();
    chk("second_death_lives", int'(lives), 1);
    cyc(8'h00, 1'b0, 1'b1, 1'b0, 0);
    chk("third_hit_lives", int'(lives), 0);
    tick_n(60);
    chk("over_state", int'(game_state), 3);
    tick_n(179);
    chk("over179_state", int'(game_state), 3);
    tick_n(1);
    chk("over180_state", int'(game_state), 0);
    chk("over180_greset", int'(game_reset), 0);
    check_model("over_timeout");

    // Enter during game over only returns to title; a second edge starts.
    cyc(8'h28, 1'b0, 1'b0, 1'b0, 0);
    chk("new_game_lives", int'(lives), 3);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 0);
    die(); die();
    cyc(8'h00, 1'b0, 1'b1, 1'b0, 0);
    tick_n(70);
    chk("over2_state", int'(game_state), 3);
    cyc(8'h28, 1'b0, 1'b0, 1'b0, 0);
    chk("over_enter_state", int'(game_state), 0);
    chk("over_enter_greset", int'(game_reset), 0);
    cyc(8'h28, 1'b0, 1'b0, 1'b0, 0);
    chk("over_enter_held_state", int'(game_state), 0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 0);
    cyc(8'h28, 1'b0, 1'b0, 1'b0, 0);
    chk("second_enter_state", int'(game_state), 1);
    chk("second_enter_greset", int'(game_reset), 1);
    check_model("second_enter");

    // Hit beats home; level saturates at 7 with one respawn per home.
    do_reset();
    cyc(8'h28, 1'b0, 1'b0, 1'b0, 0);
    cyc(8'h00, 1'b0, 1'b1, 1'b1, 0);
    chk("hit_home_state", int'(game_state), 2);
    chk("hit_home_level", int'(level), 0);
    chk("hit_home_respawn", int'(frog_respawn), 0);
    tick_n(60);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 0);
    rs_count = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(8'h00, 1'b0, 1'b0, 1'b1, 0);
      rs_count += int'(frog_respawn);
    end
    chk("home9_level", int'(level), 7);
    chk("home9_respawns", rs_count, 9);
    cyc(8'h00, 1'b0, 1'b1, 1'b1, 0);
    chk("sat_hit_home_state", int'(game_state), 2);
    chk("sat_hit_home_level", int'(level), 7);
    chk("sat_hit_home_respawn", int'(frog_respawn), 0);

    // High score keep / abort / clear.
    do_reset();
    cyc(8'h28, 1'b0, 1'b0, 1'b0, 0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 120);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 80);
    chk("hs_peak", int'(high_score), 120);
    cyc(8'h29, 1'b0, 1'b0, 1'b0, 80);
    chk("esc_play_state", int'(game_state), 0);
    chk("esc_play_greset", int'(game_reset), 1);
    chk("esc_play_hs", int'(high_score), 120);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 0);
    cyc(8'h29, 1'b0, 1'b0, 1'b0, 0);
    chk("esc_idle_hs", int'(high_score), 0);
    check_model("hs_seq");

    // Asynchronous reset in the middle of a death animation.
    do_reset();
    cyc(8'h28, 1'b0, 1'b0, 1'b0, 0);
    cyc(8'h00, 1'b0, 1'b0, 1'b1, 55);
    cyc(8'h00, 1'b0, 1'b1, 1'b0, 0);
    tick_n(5);
    chk("pre_areset_state", int'(game_state), 2);
    #2;
    Reset = 1'b1;
    #1;
    chk("areset_state", int'(game_state), 0);
    chk("areset_play_en", int'(play_en), 0);
    chk("areset_lives", int'(lives), 3);
    chk("areset_level", int'(level), 0);
    chk("areset_hs", int'(high_score), 0);
    chk("areset_respawn", int'(frog_respawn), 0);
    chk("areset_greset", int'(game_reset), 0);
    do_reset();

    // Randomized run against the model.
    rkc = 8'h00;
    rsc = 0;
    for (int i = 0; i < 4000; i++) begin
      int r;
      if ($urandom_range(0, 15) == 0) begin
        r = int'($urandom_range(0, 19));
        if (r < 10)      rkc = 8'h00;
        else if (r < 15) rkc = 8'h28;
        else if (r < 16) rkc = 8'h29;
        else             rkc = 8'h04;
      end
      if ($urandom_range(0, 7) == 0) rsc = int'($urandom_range(0, 3000));
      cyc(rkc, 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 24) == 0), rsc);
      check_model($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
